// File: rtl/mul8_share_pkg.sv
// rtl/mul8_share_pkg.sv - shared types and constants for the 16x16 byte-sliced multiply sequencer
package mul8_share_pkg;

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  localparam int N_STEPS = 4;
  localparam int BYTE_W  = 8;
  localparam int OP_W    = 16;
  localparam int PROD_W  = 32;

  typedef struct packed {
    logic i;
    logic j;
  } pair_t;

  // Byte pair order (0,0),(0,1),(1,0),(1,1): i selects the A byte, j the B byte.
  function automatic pair_t step_pair(input logic [1:0] step);
    pair_t p;
    case (step)
      2'd0:    p = '{i: 1'b0, j: 1'b0};
      2'd1:    p = '{i: 1'b0, j: 1'b1};
      2'd2:    p = '{i: 1'b1, j: 1'b0};
      default: p = '{i: 1'b1, j: 1'b1};
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mul8_share_seq_if.sv
// rtl/mul8_share_seq_if.sv - request/response bundle between requesters and the multiply sequencer
interface mul8_share_seq_if
  import mul8_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [OP_W*NREQ-1:0] req_a;
  logic [OP_W*NREQ-1:0] req_b;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [ID_W-1:0]      resp_id;
  logic [PROD_W-1:0]    resp_prod;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_prod
  );

endinterface

// File: rtl/mul8_share_seq_rr_arb_oh.sv
// rtl/mul8_share_seq_rr_arb_oh.sv - combinational round-robin arbiter, first valid at or after ptr
module rr_arb_oh #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_any && valid[idx]) begin
        grant_any     = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mul8_share_seq.sv
// rtl/mul8_share_seq.sv - arbitrates 16x16 multiplies onto one shared 8x8 unit, four byte steps each
module mul8_share_seq
  import mul8_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  mul8_share_seq_if.slave   bus,
  output logic [BYTE_W-1:0] mul_a,
  output logic [BYTE_W-1:0] mul_b,
  input  logic [OP_W-1:0]   mul_p,
  output logic              busy
);

  state_t            state, state_d;
  logic [1:0]        step, step_d;
  logic [OP_W-1:0]   op_a, op_a_d, op_b, op_b_d;
  logic [ID_W-1:0]   id, id_d, rr_ptr, rr_ptr_d;
  logic [PROD_W-1:0] acc, acc_d, resp_prod_q, resp_prod_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;

  logic [NREQ-1:0]   grant_oh;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [OP_W-1:0]   sel_a, sel_b;
  pair_t             pair;
  logic [1:0]        byte_sum;
  logic [4:0]        shamt;
  logic [PROD_W-1:0] term;

  rr_arb_oh #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .valid     (bus.req_valid),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_oh[k]) begin
        sel_a = sel_a | bus.req_a[OP_W*k +: OP_W];
        sel_b = sel_b | bus.req_b[OP_W*k +: OP_W];
      end
    end
  end

  // Operands come straight from captured registers so the shared unit sees a whole-cycle stable input.
  assign pair     = step_pair(step);
  assign mul_a    = (state == MUL) ? (pair.i ? op_a[15:8] : op_a[7:0]) : '0;
  assign mul_b    = (state == MUL) ? (pair.j ? op_b[15:8] : op_b[7:0]) : '0;
  assign byte_sum = {1'b0, pair.i} + {1'b0, pair.j};
  assign shamt    = {byte_sum, 3'b000};
  assign term     = PROD_W'(mul_p) << shamt;

  assign busy           = (state != IDLE);
  assign bus.req_ready  = (state == IDLE) ? grant_oh : '0;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_prod  = resp_prod_q;
  assign bus.resp_id    = resp_id_q;

  always_comb begin
    state_d     = state;
    step_d      = step;
    op_a_d      = op_a;
    op_b_d      = op_b;
    id_d        = id;
    rr_ptr_d    = rr_ptr;
    acc_d       = acc;
    resp_prod_d = resp_prod_q;
    resp_id_d   = resp_id_q;
    case (state)
      IDLE: begin
        if (grant_any) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          id_d     = grant_idx;
          acc_d    = '0;
          step_d   = '0;
          rr_ptr_d = (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = MUL;
        end
      end
      MUL: begin
        acc_d  = acc + term;
        step_d = step + 2'd1;
        if (step == 2'(N_STEPS - 1)) begin
          resp_prod_d = acc + term;
          resp_id_d   = id;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      step        <= '0;
      op_a        <= '0;
      op_b        <= '0;
      id          <= '0;
      rr_ptr      <= '0;
      acc         <= '0;
      resp_prod_q <= '0;
      resp_id_q   <= '0;
    end else begin
      state       <= state_d;
      step        <= step_d;
      op_a        <= op_a_d;
      op_b        <= op_b_d;
      id          <= id_d;
      rr_ptr      <= rr_ptr_d;
      acc         <= acc_d;
      resp_prod_q <= resp_prod_d;
      resp_id_q   <= resp_id_d;
    end
  end

endmodule

// File: tb/tb_mul8_share_seq.sv
// tb/tb_mul8_share_seq.sv - directed bench for mul8_share_seq with a behavioural 8x8 unit
module tb_mul8_share_seq;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mul_a, mul_b;
  logic [15:0] mul_p;
  logic       busy;

  int n_err = 0;
  int n_chk = 0;

  logic [15:0] rr_a [4];
  logic [15:0] rr_b [4];
  logic [31:0] rr_p [4];

  mul8_share_seq_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  mul8_share_seq #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  assign mul_p = 16'(mul_a) * 16'(mul_b);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[16*k +: 16] = a;
    bus.req_b[16*k +: 16] = b;
  endtask

  // Grant k in IDLE, then wait out four MUL cycles and check the response.
  task automatic single(input string tag, input int k, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] exp);
    @(negedge clk);
    set_op(k, a, b);
    bus.req_valid = 4'(1 << k);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << k));
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_prod"}, bus.resp_prod, exp);
    chk({tag, "_id"}, 32'(bus.resp_id), 32'(k));
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_resp_prod", bus.resp_prod, 0);
    chk("rst_resp_id", 32'(bus.resp_id), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;

    // Single request with the byte operand sequence observed per step.
    @(negedge clk);
    set_op(0, 16'h1234, 16'h5678);
    bus.req_valid = 4'b0001;
    #1 chk("s0_ready", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = '0;
    chk("s0_busy", 32'(busy), 1);
    chk("s0_step0", {16'h0, mul_a, mul_b}, 32'h3478);
    chk("s0_ready_mul", 32'(bus.req_ready), 0);
    @(negedge clk) chk("s0_step1", {16'h0, mul_a, mul_b}, 32'h3456);
    @(negedge clk) chk("s0_step2", {16'h0, mul_a, mul_b}, 32'h1278);
    @(negedge clk) chk("s0_step3", {16'h0, mul_a, mul_b}, 32'h1256);
    @(negedge clk);
    chk("s0_valid", 32'(bus.resp_valid), 1);
    chk("s0_prod", bus.resp_prod, 32'h06260060);
    chk("s0_id", 32'(bus.resp_id), 0);
    chk("s0_mul_a_idle", 32'(mul_a), 0);
    @(negedge clk);
    chk("s0_done", 32'(bus.resp_valid), 0);

    single("ext_ffff", 1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    single("ext_zero", 2, 16'h0000, 16'hFFFF, 32'h00000000);
    single("ext_0100", 3, 16'h0100, 16'h0100, 32'h00010000);

    // Round robin from pointer 0 with all four requesters held valid.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rr_a[0] = 16'h0002; rr_b[0] = 16'h0003; rr_p[0] = 32'h00000006;
    rr_a[1] = 16'h0010; rr_b[1] = 16'h0010; rr_p[1] = 32'h00000100;
    rr_a[2] = 16'h1000; rr_b[2] = 16'h1000; rr_p[2] = 32'h01000000;
    rr_a[3] = 16'h00FF; rr_b[3] = 16'h0101; rr_p[3] = 32'h0000FFFF;
    for (int k = 0; k < 4; k++) set_op(k, rr_a[k], rr_b[k]);
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 chk($sformatf("rr%0d_grant", g), 32'(bus.req_ready), 32'(1 << (g % 4)));
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        chk($sformatf("rr%0d_noready_c%0d", g, c), 32'(bus.req_ready), 0);
      end
      chk($sformatf("rr%0d_id", g), 32'(bus.resp_id), 32'(g % 4));
      chk($sformatf("rr%0d_prod", g), bus.resp_prod, rr_p[g % 4]);
      @(negedge clk);
    end
    bus.req_valid = '0;

    // Backpressure: response held 10 cycles while requester 2 waits.
    @(negedge clk);
    bus.resp_ready = 1'b0;
    set_op(1, 16'hABCD, 16'h0002);
    set_op(2, 16'h0003, 16'h0005);
    bus.req_valid = 4'b0110;
    #1 chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = 4'b0100;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_valid_%0d", c), 32'(bus.resp_valid), 1);
      chk($sformatf("bp_prod_%0d", c), bus.resp_prod, 32'h0001579A);
      chk($sformatf("bp_id_%0d", c), 32'(bus.resp_id), 1);
      chk($sformatf("bp_noready_%0d", c), 32'(bus.req_ready), 0);
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released", 32'(bus.resp_valid), 0);
    chk("bp_next_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("bp2_prod", bus.resp_prod, 32'h0000000F);
    chk("bp2_id", 32'(bus.resp_id), 2);
    @(negedge clk);

    // Operand change after grant must not reach the result.
    @(negedge clk);
    set_op(3, 16'h1111, 16'h0011);
    bus.req_valid = 4'b1000;
    #1 chk("opc_grant", 32'(bus.req_ready), 32'h8);
    @(negedge clk);
    bus.req_valid = '0;
    set_op(3, 16'hFFFF, 16'hFFFF);
    #1 chk("opc_step0", {16'h0, mul_a, mul_b}, 32'h1111);
    repeat (4) @(negedge clk);
    chk("opc_prod", bus.resp_prod, 32'h00012221);
    chk("opc_id", 32'(bus.resp_id), 3);
    @(negedge clk);

    // Reset at MUL step 2 drops the request and returns the pointer to 0.
    @(negedge clk);
    set_op(2, 16'h4321, 16'h8765);
    bus.req_valid = 4'b0100;
    #1 chk("mr_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_valid", 32'(bus.resp_valid), 0);
    chk("mr_prod", bus.resp_prod, 0);
    chk("mr_id", 32'(bus.resp_id), 0);
    chk("mr_mul", {16'h0, mul_a, mul_b}, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("mr_no_resp_%0d", c), 32'(bus.resp_valid), 0);
    end
    set_op(1, 16'h0007, 16'h0009);
    set_op(3, 16'h0005, 16'h0005);
    bus.req_valid = 4'b1010;
    #1 chk("mr_ptr0_grant", 32'(bus.req_ready), 32'h2);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    chk("mr_after_prod", bus.resp_prod, 32'h0000003F);
    chk("mr_after_id", 32'(bus.resp_id), 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
